// File: rtl/clk_divider.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// clk_divider
//
// Integer clock divider producing a 50 %-duty, glitch-free slow clock from a
// fast system clock. Also produces single-cycle rise/fall strobes aligned with
// the clk_out transitions, so downstream logic can stay in the clk_in domain.
//
// Parameters:
//   CLK_DIV  half-period of clk_out in clk_in cycles (>= 1)
//   CNT_W    counter width, derived from CLK_DIV (never below 1)
//
// Ports:
//   clk_in     system clock, all state changes on its rising edge
//   resetn     asynchronous active-low reset
//   clk_out    divided clock, period 2*CLK_DIV clk_in cycles, registered
//   rise_tick  one clk_in cycle high in the cycle clk_out goes 0->1
//   fall_tick  one clk_in cycle high in the cycle clk_out goes 1->0
// -----------------------------------------------------------------------------
module clk_divider #(
    parameter int CLK_DIV = 250,
    parameter int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic clk_in,
    input  logic resetn,
    output logic clk_out,
    output logic rise_tick,
    output logic fall_tick
);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("clk_divider: CLK_DIV must be >= 1 (got %0d)", CLK_DIV);
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    // The counter wraps only through this compare, never by natural overflow,
    // so power-of-two divisors behave exactly like any other value.
    assign wrap = (cnt == CNT_MAX);

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            clk_out   <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else if (wrap) begin
            cnt       <= '0;
            clk_out   <= ~clk_out;
            // Ticks are derived from the pre-toggle value so they land on the
            // same edge as the clk_out transition they describe.
            rise_tick <= ~clk_out;
            fall_tick <= clk_out;
        end else begin
            cnt       <= cnt + 1'b1;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_divider.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_clk_divider
//
// Drives three clk_divider instances (CLK_DIV = 250, 1, 4) from a 50 MHz clock
// with a shared reset. Expected outputs are computed from the number of edges
// since reset release and queued per edge, then compared after the edge.
// -----------------------------------------------------------------------------
module tb_clk_divider;

    logic clk_50m = 1'b0;
    logic resetn;

    logic c250, r250, f250;
    logic c1,   r1,   f1;
    logic c4,   r4,   f4;

    always #10 clk_50m = ~clk_50m;

    clk_divider #(.CLK_DIV(250)) dut250 (
        .clk_in(clk_50m), .resetn(resetn),
        .clk_out(c250), .rise_tick(r250), .fall_tick(f250)
    );

    clk_divider #(.CLK_DIV(1)) dut1 (
        .clk_in(clk_50m), .resetn(resetn),
        .clk_out(c1), .rise_tick(r1), .fall_tick(f1)
    );

    clk_divider #(.CLK_DIV(4)) dut4 (
        .clk_in(clk_50m), .resetn(resetn),
        .clk_out(c4), .rise_tick(r4), .fall_tick(f4)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {clk_out, rise_tick, fall_tick} after edge n since release.
    function automatic logic [2:0] model(input int d, input int n);
        int   k;
        logic c;
        logic t;
        if (n == 0) return 3'b000;
        k = n / d;
        c = k[0];
        t = ((n % d) == 0);
        return {c, t && c, t && !c};
    endfunction

    typedef struct {
        int         id;
        logic [2:0] outs;
        int         cnt;
    } sb_t;

    sb_t sb_q[$];
    int  n_edge;

    // Observations on the CLK_DIV = 250 instance
    logic prev_c250;
    int   rise_edge [8];
    int   fall_edge [8];
    time  rise_t    [8];
    time  fall_t    [8];
    int   n_rise, n_fall;
    int   rise_ticks, fall_ticks;

    task automatic clear_obs();
        n_edge     = 0;
        prev_c250  = 1'b0;
        n_rise     = 0;
        n_fall     = 0;
        rise_ticks = 0;
        fall_ticks = 0;
        for (int i = 0; i < 8; i++) begin
            rise_edge[i] = -1; fall_edge[i] = -1;
            rise_t[i]    = 0;  fall_t[i]    = 0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_250"}, {c250, r250, f250}, 3'b000);
        check({tag, "_1"},   {c1,   r1,   f1},   3'b000);
        check({tag, "_4"},   {c4,   r4,   f4},   3'b000);
    endtask

    // One clk_in edge: queue expectations, then compare what the DUTs produced.
    task automatic step();
        sb_t        e;
        logic [2:0] obs;
        int         obs_cnt;
        string      name;
        @(posedge clk_50m);
        n_edge++;
        sb_q.push_back('{0, model(250, n_edge), n_edge % 250});
        sb_q.push_back('{1, model(1,   n_edge), 0});
        sb_q.push_back('{2, model(4,   n_edge), n_edge % 4});
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.id)
                0:       begin obs = {c250, r250, f250}; obs_cnt = int'(dut250.cnt); name = "d250"; end
                1:       begin obs = {c1,   r1,   f1};   obs_cnt = int'(dut1.cnt);   name = "d1";   end
                default: begin obs = {c4,   r4,   f4};   obs_cnt = int'(dut4.cnt);   name = "d4";   end
            endcase
            check({name, "_outs"}, obs, e.outs);
            check({name, "_cnt"},  obs_cnt, e.cnt);
            check({name, "_excl"}, obs[1] & obs[0], 1'b0);
        end
        if (c250 && !prev_c250 && n_rise < 8) begin
            rise_edge[n_rise] = n_edge; rise_t[n_rise] = $time; n_rise++;
        end
        if (!c250 && prev_c250 && n_fall < 8) begin
            fall_edge[n_fall] = n_edge; fall_t[n_fall] = $time; n_fall++;
        end
        prev_c250 = c250;
        if (n_edge <= 2000) begin
            if (r250) rise_ticks++;
            if (f250) fall_ticks++;
        end
    endtask

    // Assert reset between clock edges, check it acts without a clock edge,
    // hold for two cycles, then release on a falling edge.
    task automatic apply_reset(input string tag);
        #4 resetn = 1'b0;
        #1 check_all_zero({tag, "_async"});
        repeat (2) begin
            @(posedge clk_50m);
            #1 check_all_zero({tag, "_hold"});
        end
        @(negedge clk_50m);
        resetn = 1'b1;
        clear_obs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0t, expected < 500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b1;
        clear_obs();

        // Power-up reset, before any clock edge
        apply_reset("rst");

        // Nominal run over a bit more than 4 output periods
        repeat (2010) step();
        check("rise1_edge", rise_edge[0], 250);
        check("fall1_edge", fall_edge[0], 500);
        check("rise2_edge", rise_edge[1], 750);
        check("period_a",   rise_t[1] - rise_t[0], 10000);
        check("period_b",   rise_t[2] - rise_t[1], 10000);
        check("high_time",  fall_t[0] - rise_t[0], 5000);
        check("rise_ticks", rise_ticks, 4);
        check("fall_ticks", fall_ticks, 4);

        // Reset in the middle of a high phase
        apply_reset("rst2");
        repeat (300) step();
        check("midhigh_pre", c250, 1'b1);
        apply_reset("midhigh");
        repeat (510) step();
        check("restart_rise", rise_edge[0], 250);
        check("restart_fall", fall_edge[0], 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
